// File: rtl/aud_recorder_if.sv
// Codec/control/SRAM-write signal bundle for aud_recorder.
// The slave modport is the recorder; the master modport drives the codec and control pulses.
interface aud_recorder_if;
   logic        i_lrc;
   logic        i_data;
   logic        i_start;
   logic        i_pause;
   logic        i_stop;
   logic [19:0] o_address;
   logic [15:0] o_data;
   logic        o_valid;
   logic        o_full;
   logic        o_busy;

   modport master (
      output i_lrc, i_data, i_start, i_pause, i_stop,
      input  o_address, o_data, o_valid, o_full, o_busy
   );

   modport slave (
      input  i_lrc, i_data, i_start, i_pause, i_stop,
      output o_address, o_data, o_valid, o_full, o_busy
   );
endinterface

// File: rtl/aud_recorder.sv
// WM8731 I2S ADC capture: 16-bit words written to consecutive SRAM word addresses.
// Define AUD_RECORDER_STEREO_EN to also capture right-channel (rising LRC) words.
module aud_recorder (
   input logic           i_clk,
   input logic           i_rst_n,
   aud_recorder_if.slave bus
);

   typedef enum logic [2:0] {
      StIdle, StWaitLrc, StDelay, StShift, StWrite, StPaused, StFull
   } state_e;

   state_e      state_q, state_d;
   logic        lrc_q;
   logic [3:0]  bit_cnt_q, bit_cnt_d;
   logic [15:0] shift_q, shift_d;
   logic [15:0] data_q, data_d;
   logic [19:0] address_q, address_d;
   logic        full_q, full_d;
   logic        pause_q, pause_d;
   logic        busy;
   logic        lrc_fall;
   logic        frame_start;

   assign lrc_fall = lrc_q & ~bus.i_lrc;

`ifdef AUD_RECORDER_STEREO_EN
   logic lrc_rise;
   assign lrc_rise    = ~lrc_q & bus.i_lrc;
   assign frame_start = lrc_fall | lrc_rise;
`else
   assign frame_start = lrc_fall;
`endif

   assign busy = state_q inside {StWaitLrc, StDelay, StShift, StWrite};

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         lrc_q     <= 1'b1;
         bit_cnt_q <= 4'd0;
         shift_q   <= 16'd0;
         data_q    <= 16'd0;
         address_q <= 20'd0;
         full_q    <= 1'b0;
         pause_q   <= 1'b0;
      end else begin
         lrc_q     <= bus.i_lrc;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         address_q <= address_d;
         full_q    <= full_d;
         pause_q   <= pause_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      data_d    = data_q;
      address_d = address_q;
      full_d    = full_q;
      pause_d   = pause_q;
      if (busy && bus.i_pause) begin
         pause_d = 1'b1;
      end
      // Stop beats everything, including a simultaneous start.
      if (bus.i_stop && state_q != StIdle) begin
         state_d   = StIdle;
         pause_d   = 1'b0;
         bit_cnt_d = 4'd0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.i_start && !bus.i_stop) begin
                  address_d = 20'd0;
                  full_d    = 1'b0;
                  pause_d   = 1'b0;
                  state_d   = StWaitLrc;
               end
            end
            StWaitLrc: begin
               if (frame_start) state_d = StDelay;
            end
            StDelay: begin
               bit_cnt_d = 4'd0;
               state_d   = StShift;
            end
            StShift: begin
               shift_d[4'd15 - bit_cnt_q] = bus.i_data;
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q == 4'd15) begin
                  data_d  = shift_d;
                  state_d = StWrite;
               end
            end
            StWrite: begin
               pause_d = 1'b0;
               if (address_q == 20'hFFFFF) begin
                  full_d  = 1'b1;
                  state_d = StFull;
               end else begin
                  address_d = address_q + 20'd1;
                  state_d   = (pause_q || bus.i_pause) ? StPaused : StWaitLrc;
               end
            end
            StPaused: begin
               if (bus.i_start) state_d = StWaitLrc;
            end
            StFull: begin
               state_d = StFull;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      bus.o_valid   = (state_q == StWrite);
      bus.o_busy    = busy;
      bus.o_address = address_q;
      bus.o_data    = data_q;
      bus.o_full    = full_q;
   end

endmodule

// File: doc/aud_recorder.md
AUD_RECORDER -- requirements
Module: aud_recorder

Interface
REQ-001 SHALL have port i_clk  input  1  single clock; WM8731 BCLK domain; all logic on rising edge.
REQ-002 SHALL have port i_rst_n  input  1  reset; synchronous, active-low.
REQ-003 SHALL have port i_lrc  input  1  codec ADCLRCK; low = left channel, high = right channel.
REQ-004 SHALL have port i_data  input  1  codec ADCDAT serial bit, MSB first.
REQ-005 SHALL have port i_start  input  1  one-cycle pulse; begin a new recording or resume from pause.
REQ-006 SHALL have port i_pause  input  1  one-cycle pulse; pause at the next word boundary.
REQ-007 SHALL have port i_stop  input  1  one-cycle pulse; abort and return to idle.
REQ-008 SHALL have port o_address  output  20  SRAM word address of the current or next sample.
REQ-009 SHALL have port o_data  output  16  captured sample.
REQ-010 SHALL have port o_valid  output  1  one-cycle write strobe; o_address/o_data valid while high.
REQ-011 SHALL have port o_full  output  1  high once address 20'hFFFFF has been written.
REQ-012 SHALL have port o_busy  output  1  high in WAIT_LRC, DELAY, SHIFT or WRITE.

Function
REQ-013 SHALL implement states IDLE, WAIT_LRC, DELAY, SHIFT, WRITE, PAUSED, FULL.
REQ-014 SHALL register i_lrc into lrc_q; falling edge = (lrc_q==1 && i_lrc==0), sampled at the posedge.
REQ-015 IDLE + i_start SHALL clear o_address to 0 and o_full to 0, then go to WAIT_LRC.
REQ-016 WAIT_LRC + falling edge SHALL go to DELAY; the i_data bit at that edge is discarded (I2S one-BCLK delay).
REQ-017 DELAY SHALL last exactly one cycle, then go to SHIFT with bit counter 0.
REQ-018 SHALL shift i_data into bit 15-n on SHIFT cycle n (n=0..15); after n=15, go to WRITE.
REQ-019 WRITE SHALL last one cycle with o_valid=1, o_data=captured word and o_address=word address.
REQ-020 In the cycle after WRITE, o_address SHALL increment by 1.
REQ-021 After WRITE, the FSM SHALL go to WAIT_LRC, or to PAUSED if a pause is pending.
REQ-022 i_pause in any busy state SHALL set a pause-pending flag; the current word SHALL still complete and be written.
REQ-023 PAUSED + i_start SHALL go to WAIT_LRC with o_address unchanged.
REQ-024 i_stop in any state except IDLE SHALL go to IDLE next cycle; a partial word SHALL be discarded with no o_valid, and o_address SHALL be held.
REQ-025 i_start and i_stop in the same cycle: i_stop SHALL win.
REQ-026 i_start while busy SHALL be ignored.
REQ-027 A WRITE at address 20'hFFFFF SHALL set o_full=1 and go to FULL with no address wrap; only i_stop leaves FULL.
REQ-028 In mono mode, rising edges of i_lrc SHALL be ignored in every state.

Reset
REQ-029 While i_rst_n=0 at a posedge: state=IDLE, o_address=0, o_data=0, o_valid=0, o_full=0, o_busy=0, lrc_q=1, pause flag=0, bit counter=0.
REQ-030 Reset mid-word SHALL discard the word and produce no o_valid.

Configuration
REQ-031 Macro AUD_RECORDER_STEREO_EN: when defined, a rising edge of i_lrc in WAIT_LRC SHALL also start a capture (right channel), using the same DELAY/SHIFT/WRITE sequence.
REQ-032 With AUD_RECORDER_STEREO_EN, left and right words SHALL be written to consecutive addresses in order of arrival.
REQ-033 Without AUD_RECORDER_STEREO_EN, only left (falling-edge) words SHALL be captured (mono).

Verification
REQ-034 Reset, i_start, then left word 16'h8001 (framed as described in REQ-016 to REQ-018) -> o_valid for exactly one cycle with o_data=16'h8001 and o_address=0; o_address=1 on the next cycle.
REQ-035 Three consecutive left words 16'hA5A5, 16'h0001, 16'hFFFF -> writes to addresses 0, 1, 2 in order; mono build shows no writes on i_lrc rising edges.
REQ-036 i_pause at SHIFT bit 7 of word 16'h1234 -> 16'h1234 is written and the FSM enters PAUSED; i_start resumes and the next word goes to address 1.
REQ-037 i_stop at SHIFT bit 10 -> no o_valid, state IDLE and o_address held; a following i_start gives o_address=0.
REQ-038 Preload o_address=20'hFFFFF by forcing, then capture one word -> o_valid at 20'hFFFFF, o_full=1, and no further writes despite continued LRC activity.
REQ-039 Stereo build, left word 16'h1111 then right word 16'h2222 -> writes to address 0 (16'h1111) and address 1 (16'h2222).
